// File: rtl/ngp_pkg.sv
// Shared definitions for the NGP writeback stage.
//   wb_state_e : writeback FSM states
//   DST_A/DST_D/DST_M : bit positions inside the 3-bit destination mask
package ngp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } wb_state_e;

  localparam int DST_A = 2;
  localparam int DST_D = 1;
  localparam int DST_M = 0;

endpackage

// File: rtl/ngp_writeback.sv
// NGP writeback stage: commits a handler result into the architectural
// A/D registers and the program counter, performs the optional *A store and
// refreshes the cached mem[A] value through a single-request memory port.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      result handshake (ready only while idle)
//   result, jmp, dst         handler output, branch-taken flag, dest mask
//   a_reg, d_reg, amem_reg   architectural A, D and cached mem[A]
//   pc                       fetch program counter
//   retire                   one-cycle completion pulse
//   mem_req/we/addr/wdata    data-memory request, held until mem_ack
//   mem_ack, mem_rdata       memory completion and read data
module ngp_writeback
  import ngp_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] result,
  input  logic        jmp,
  input  logic [2:0]  dst,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic [15:0] amem_reg,
  output logic [15:0] pc,
  output logic        retire,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  wb_state_e   state_q;
  logic [15:0] a_q, d_q, amem_q, pc_q;
  logic [15:0] a_d, d_d, pc_d;
  logic        retire_q;
  logic        mem_req_q, mem_we_q;
  logic [15:0] mem_addr_q, mem_wdata_q;
  // Remembers that the held instruction also wrote A, so the store must be
  // followed by a refresh read of the new A.
  logic        rd_after_wr_q;

  // Next architectural values for an accept; every source uses pre-accept A.
  always_comb begin
    a_d  = dst[DST_A] ? result : a_q;
    d_d  = dst[DST_D] ? result : d_q;
    pc_d = jmp ? a_q : (pc_q + 16'd1);
  end

  // Writeback FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= 16'h0000;
      d_q           <= 16'h0000;
      amem_q        <= 16'h0000;
      pc_q          <= RESET_PC;
      retire_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_wdata_q   <= 16'h0000;
      rd_after_wr_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q           <= a_d;
            d_q           <= d_d;
            pc_q          <= pc_d;
            rd_after_wr_q <= dst[DST_A];
            if (dst[DST_M]) begin
              mem_addr_q  <= a_q;
              mem_wdata_q <= result;
              mem_we_q    <= 1'b1;
              mem_req_q   <= 1'b1;
              state_q     <= ST_WR_WAIT;
            end else if (dst[DST_A]) begin
              mem_addr_q <= result;
              mem_we_q   <= 1'b0;
              mem_req_q  <= 1'b1;
              state_q    <= ST_RD_WAIT;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_WR_WAIT: begin
          if (mem_ack) begin
            amem_q   <= mem_wdata_q;
            mem_we_q <= 1'b0;
            if (rd_after_wr_q) begin
              // Chain straight into the read: mem_req stays high.
              mem_addr_q <= a_q;
              state_q    <= ST_RD_WAIT;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_RD_WAIT: begin
          if (mem_ack) begin
            amem_q    <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          retire_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign a_reg     = a_q;
  assign d_reg     = d_q;
  assign amem_reg  = amem_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ngp_writeback.sv
// Scoreboard bench for ngp_writeback: a high-level instruction model queues
// the expected memory transactions and retire snapshots; a monitor pops and
// compares them as the DUT presents them. A responder plays data memory.
module tb_ngp_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        jmp;
  logic [2:0]  dst;
  logic [15:0] a_reg, d_reg, amem_reg, pc;
  logic        retire;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  ngp_writeback #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .jmp(jmp), .dst(dst),
    .a_reg(a_reg), .d_reg(d_reg), .amem_reg(amem_reg), .pc(pc),
    .retire(retire), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // kind: 0 = memory write, 1 = memory read, 2 = retire
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] a, d, pcv, amem;
    int          acc_cyc;
    bit          nomem;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   force_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten memory locations hold a fixed pattern derived from the address.
  function automatic logic [15:0] mem_init(input logic [15:0] addr);
    return {addr[7:0], addr[15:8]} ^ 16'h5A3C;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] m_a, m_d, m_pc, m_amem;
  logic [15:0] m_mem [logic [15:0]];
  logic [15:0] r_mem [logic [15:0]];

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    if (m_mem.exists(addr)) return m_mem[addr];
    return mem_init(addr);
  endfunction

  function automatic logic [15:0] resp_read(input logic [15:0] addr);
    if (r_mem.exists(addr)) return r_mem[addr];
    return mem_init(addr);
  endfunction

  task automatic model_reset();
    m_a = 16'h0000; m_d = 16'h0000; m_amem = 16'h0000; m_pc = 16'h0010;
    m_mem.delete();
    r_mem.delete();
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [15:0] res, input logic [2:0] dv, input bit jv, input int c);
    exp_t        e;
    logic [15:0] a_old;
    bit          touched;
    a_old   = m_a;
    touched = 1'b0;
    if (dv[0]) begin
      e = '{kind: 0, addr: a_old, data: res, a: 16'h0, d: 16'h0, pcv: 16'h0, amem: 16'h0, acc_cyc: c, nomem: 1'b0};
      sb_q.push_back(e);
      m_mem[a_old] = res;
      m_amem  = res;
      touched = 1'b1;
    end
    if (dv[2]) m_a = res;
    if (dv[1]) m_d = res;
    if (dv[2]) begin
      e = '{kind: 1, addr: res, data: 16'h0, a: 16'h0, d: 16'h0, pcv: 16'h0, amem: 16'h0, acc_cyc: c, nomem: 1'b0};
      sb_q.push_back(e);
      m_amem  = model_read(res);
      touched = 1'b1;
    end
    m_pc = jv ? a_old : m_pc + 16'd1;
    e = '{kind: 2, addr: 16'h0, data: 16'h0, a: m_a, d: m_d, pcv: m_pc, amem: m_amem, acc_cyc: c, nomem: !touched};
    sb_q.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  int wait_cnt = 0;

  function automatic int pick_delay();
    if (force_delay >= 0) return force_delay;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mem_ack  = 1'b0;
        wait_cnt = pick_delay();
        continue;
      end
      if (mem_req && mem_ack) begin
        if (mem_we) r_mem[mem_addr] = mem_wdata;
        wait_cnt = pick_delay();
      end
      #1;
      if (mem_req) begin
        mem_ack   = (wait_cnt == 0);
        mem_rdata = resp_read(mem_addr);
        if (wait_cnt > 0) wait_cnt--;
      end else begin
        // Spurious acks while no request is pending must be ignored.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
        wait_cnt  = pick_delay();
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'h0, p_wdata = 16'h0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_req = 1'b0;
        p_ack = 1'b0;
        continue;
      end
      if (mem_req && p_req && !p_ack) begin
        check("req_stable_addr", {16'h0, mem_addr}, {16'h0, p_addr});
        check("req_stable_we", {31'h0, mem_we}, {31'h0, p_we});
        if (mem_we) check("req_stable_wdata", {16'h0, mem_wdata}, {16'h0, p_wdata});
      end
      if (mem_req && mem_ack) begin
        if (sb_q.size() == 0) begin
          check("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("mem_kind", {31'h0, mem_we}, (e.kind == 0) ? 32'd1 : 32'd0);
          check("mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
          if (e.kind == 0) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, e.data});
        end
      end
      if (retire) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("retire_order", e.kind, 32'd2);
          check("retire_a_reg", {16'h0, a_reg}, {16'h0, e.a});
          check("retire_d_reg", {16'h0, d_reg}, {16'h0, e.d});
          check("retire_pc", {16'h0, pc}, {16'h0, e.pcv});
          check("retire_amem_reg", {16'h0, amem_reg}, {16'h0, e.amem});
          if (e.nomem) check("retire_latency", cyc, e.acc_cyc + 2);
        end
      end
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; drives junk (possibly valid) while busy, then
  // presents the instruction once in_ready is seen and returns one cycle later.
  task automatic issue(input logic [15:0] res, input logic [2:0] dv, input bit jv);
    int guard = 0;
    while (!in_ready) begin
      in_valid = 1'($urandom_range(0, 1));
      result   = 16'($urandom);
      dst      = 3'($urandom);
      jmp      = 1'($urandom);
      guard++;
      if (guard > 200) begin
        check("issue_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    result   = res;
    dst      = dv;
    jmp      = jv;
    model_accept(res, dv, jv, cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", sb_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_reg"}, {16'h0, a_reg}, 32'h0);
    check({tag, "_d_reg"}, {16'h0, d_reg}, 32'h0);
    check({tag, "_amem_reg"}, {16'h0, amem_reg}, 32'h0);
    check({tag, "_pc"}, {16'h0, pc}, 32'h0010);
    check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    check({tag, "_retire"}, {31'h0, retire}, 32'h0);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    result   = 16'h0000;
    jmp      = 1'b0;
    dst      = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // D write only, no memory traffic, fixed retire latency.
    issue(16'h1234, 3'b010, 1'b0);
    // Set A = 0x0040, then store to *A and load A with a slow memory.
    issue(16'h0040, 3'b100, 1'b0);
    force_delay = 3;
    issue(16'h0080, 3'b101, 1'b0);
    drain();
    force_delay = -1;
    // Jump to old A while loading a new A.
    issue(16'h0200, 3'b100, 1'b0);
    issue(16'h0005, 3'b100, 1'b1);
    // pc wrap: jump to 0xFFFF then advance.
    issue(16'hFFFF, 3'b100, 1'b0);
    issue(16'h0000, 3'b000, 1'b1);
    issue(16'h0000, 3'b000, 1'b0);
    drain();
    check("pc_wrap", {16'h0, pc}, 32'h0000);

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      issue(r, 3'($urandom), 1'($urandom));
    end
    drain();

    // Reset while a store is outstanding.
    force_delay = 20;
    issue(16'h1111, 3'b001, 1'b0);
    check("wr_wait_req_high", {31'h0, mem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    force_delay = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom), 3'($urandom), 1'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ngp_writeback.md
NGP_WRITEBACK -- requirements
Module: ngp_writeback

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  handler result valid this cycle.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 result  input  16  ALU/branch output from the handler.
REQ-007 jmp  input  1  branch taken; PC target is current A.
REQ-008 dst  input  3  destination mask; bit2=A, bit1=D, bit0=*A.
REQ-009 a_reg, d_reg  output  16 each  architectural A and D, fed back to handler as rx_reg/ry_reg.
REQ-010 amem_reg  output  16  cached mem[A], fed back to handler as rx_mem_reg.
REQ-011 pc  output  16  program counter for fetch.
REQ-012 retire  output  1  one-cycle pulse when the accepted instruction completes.
REQ-013 mem_req, mem_we  output  1 each  data-memory request; write when mem_we=1, else read.
REQ-014 mem_addr, mem_wdata  output  16 each  request address and write data.
REQ-015 mem_ack  input  1  memory completes the pending request this cycle.
REQ-016 mem_rdata  input  16  read data, valid when mem_ack=1 on a read.

Function
REQ-017 States: IDLE, WR_WAIT, RD_WAIT, DONE; in_ready=1 only in IDLE.
REQ-018 Accept occurs on a rising edge with in_valid=1 and in_ready=1; in_valid in other states is ignored.
REQ-019 At accept: A<=result if dst[2]; D<=result if dst[1]; pc<=A_old if jmp, else pc+1 (mod 2^16).
REQ-020 All destinations use pre-accept values: *A write address and jump target equal A_old.
REQ-021 At accept, if dst[0]: mem_addr<=A_old, mem_wdata<=result, mem_we<=1, mem_req<=1, next WR_WAIT.
REQ-022 Else if dst[2]: mem_addr<=result, mem_we<=0, mem_req<=1, next RD_WAIT.
REQ-023 Else next DONE.
REQ-024 WR_WAIT on mem_ack: amem_reg<=mem_wdata; if dst[2] of the held instruction, issue a read of new A (next RD_WAIT), else DONE.
REQ-025 RD_WAIT on mem_ack: amem_reg<=mem_rdata, next DONE.
REQ-026 DONE: retire=1 for exactly one cycle, then IDLE; minimum accept-to-accept spacing is 2 cycles.
REQ-027 mem_req, mem_we, mem_addr, mem_wdata stay stable from assertion until the edge where mem_ack=1.
REQ-028 mem_ack in the first cycle of mem_req is legal; mem_req deasserts on the following edge unless a new request is chained.
REQ-029 When WR_WAIT chains to RD_WAIT, mem_req stays high, and mem_we and mem_addr switch on the same edge.
REQ-030 mem_ack while mem_req=0 is ignored.
REQ-031 dst=3'b000 with jmp=0 still advances pc and retires.
REQ-032 There is no timeout; the FSM waits indefinitely for mem_ack.

Reset
REQ-033 While rst_n=0: a_reg=d_reg=amem_reg=0, pc=RESET_PC, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0.
REQ-034 Reset mid-transaction abandons the request immediately, with no retire; in_ready=1 on the first edge after release.

Structure
REQ-035 Package ngp_pkg holds the state enum and the DST_A=2, DST_D=1, DST_M=0 bit-index constants.
REQ-036 Single module with no sub-module; the held dst bit and the FSM are local registers.

Verification
REQ-037 Reset with RESET_PC=16'h0010 -> pc=16'h0010, a_reg=0, in_ready=1, mem_req=0.
REQ-038 result=16'h1234, dst=3'b010, jmp=0 -> d_reg=16'h1234, pc+1, no mem_req, retire 2 cycles after accept.
REQ-039 With A=16'h0040, accept result=16'h0080, dst=3'b101, mem_ack delayed 3 cycles -> the following must occur in order:
- write addr 16'h0040, data 16'h0080;
- read addr 16'h0080;
- amem_reg=mem_rdata;
- a_reg=16'h0080;
- one retire.
REQ-040 With A=16'h0200, accept jmp=1, dst=3'b100, result=16'h0005 -> pc=16'h0200, a_reg=16'h0005, read of 16'h0005 issued.
REQ-041 With pc=16'hFFFF, accept jmp=0 -> pc=16'h0000.
REQ-042 Assert rst_n=0 in WR_WAIT -> mem_req drops asynchronously, no retire, all registers at reset values.
